// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial arithmetic controllers:
// slice width and FSM state encodings.
package nibble_serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_add_ctrl_cla4.sv
// 4-bit carry-lookahead slice. Also exposes the carry into bit 3 so the
// controller can derive signed overflow without a second adder.
module nibble_serial_add_ctrl_cla4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic               c1;
  logic               c2;

  assign g  = a & b;
  assign p  = a ^ b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller: one shared CLA4 slice processes one
// nibble per cycle; result is held with a valid/ready handshake.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 sub,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout,
  output logic                 Ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic                 c;
  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic [W-1:0]         s_r;
  logic                 cout_r;
  logic                 ovf_r;
  logic [SLICE_W-1:0]   a_nib;
  logic [SLICE_W-1:0]   b_nib;
  logic [SLICE_W-1:0]   sum_nib;
  logic                 slice_co;
  logic                 slice_c3;
  logic                 last;
  logic                 accept;

  assign accept = (state == ST_IDLE) && in_valid;
  assign last   = (cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = in_valid  ? ST_RUN  : ST_IDLE;
      ST_RUN:  state_nxt = last      ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = out_ready ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_RUN) || (state == ST_DONE);
  end

  // Operand capture: subtraction is folded in as A + ~B + 1 at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= A;
      b_r <= B ^ {W{sub}};
    end
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_r[SLICE_W*i +: SLICE_W];
        b_nib = b_r[SLICE_W*i +: SLICE_W];
      end
    end
  end

  nibble_serial_add_ctrl_cla4 u_cla4 (
    .a  (a_nib),
    .b  (b_nib),
    .ci (c),
    .s  (sum_nib),
    .co (slice_co),
    .c3 (slice_c3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      c      <= 1'b0;
      s_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            c   <= sub;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) s_r[SLICE_W*i +: SLICE_W] <= sum_nib;
          end
          c   <= slice_co;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            cout_r <= slice_co;
            ovf_r  <= slice_c3 ^ slice_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign S    = s_r;
  assign Cout = cout_r;
  assign Ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized checks of nibble_serial_add_ctrl at NIBBLES=8.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 8;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         sub;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the inputs so any late
  // sampling of A/B/sub corrupts the result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    A        = a;
    B        = b;
    sub      = s;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    sub      = 1'($urandom_range(0, 1));
  endtask

  // out_valid is set by the NIBBLES-th edge after acceptance, so it is first
  // sampled high by the consumer at acceptance edge + NIBBLES + 1.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, (W+1)'(lat), (W+1)'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] es,
                           input logic ec, input logic eo);
    chk({tag, "_S"},    {1'b0, S},          {1'b0, es});
    chk({tag, "_Cout"}, (W+1)'(Cout),       (W+1)'(ec));
    chk({tag, "_Ovf"},  (W+1)'(Ovf),        (W+1)'(eo));
  endtask

  task automatic handoff;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx   = b ^ {W{s}};
    full = {1'b0, a} + {1'b0, bx} + (W+1)'(s);
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (a[W-1] == bx[W-1]) && (es[W-1] != a[W-1]);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           stall;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    sub       = 1'b0;
    @(negedge clk);
    tick;
    tick;

    chk("rst_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b1));
    chk("rst_out_valid", (W+1)'(out_valid), (W+1)'(1'b0));
    chk("rst_busy",      (W+1)'(busy),      (W+1)'(1'b0));
    check_res("rst", '0, 1'b0, 1'b0);

    // Request present in the first cycle after reset release.
    rst_n = 1'b1;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("run_busy",     (W+1)'(busy),     (W+1)'(1'b1));
    chk("run_in_ready", (W+1)'(in_ready), (W+1)'(1'b0));
    wait_done("wrap", NIBBLES);
    check_res("wrap", 32'h0000_0000, 1'b1, 1'b0);
    handoff;
    chk("idle_in_ready", (W+1)'(in_ready), (W+1)'(1'b1));

    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("povf", NIBBLES);
    check_res("povf", 32'h8000_0000, 1'b0, 1'b1);
    handoff;

    issue(32'd5, 32'd7, 1'b1);
    wait_done("sub57", NIBBLES);
    check_res("sub57", 32'hFFFF_FFFE, 1'b0, 1'b0);
    handoff;

    issue(32'd7, 32'd5, 1'b1);
    wait_done("sub75", NIBBLES);
    check_res("sub75", 32'h0000_0002, 1'b1, 1'b0);
    handoff;

    // Back-pressure in DONE with in_valid pulsed during RUN and DONE.
    issue(32'h0000_00AB, 32'h0000_0011, 1'b0);
    tick;
    tick;
    in_valid = 1'b1;
    A        = 32'hFFFF_FFFF;
    B        = 32'hFFFF_FFFF;
    chk("hold_run_in_ready", (W+1)'(in_ready), (W+1)'(1'b0));
    tick;
    in_valid = 1'b0;
    wait_done("hold", NIBBLES - 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2);
      A        = $urandom;
      tick;
      chk("hold_out_valid", (W+1)'(out_valid), (W+1)'(1'b1));
      chk("hold_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b0));
      check_res("hold", 32'h0000_00BC, 1'b0, 1'b0);
    end
    A        = 32'h1234_5678;
    B        = 32'h0000_0001;
    sub      = 1'b0;
    in_valid = 1'b1;
    handoff;
    chk("post_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b1));
    chk("post_out_valid", (W+1)'(out_valid), (W+1)'(1'b0));
    chk("post_busy",      (W+1)'(busy),      (W+1)'(1'b0));
    tick;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    wait_done("post", NIBBLES);
    check_res("post", 32'h1234_5679, 1'b0, 1'b0);
    handoff;

    // Reset on the fourth RUN cycle aborts the operation.
    issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_out_valid", (W+1)'(out_valid), (W+1)'(1'b0));
    chk("abort_busy",      (W+1)'(busy),      (W+1)'(1'b0));
    chk("abort_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b1));
    check_res("abort", '0, 1'b0, 1'b0);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done("after_abort", NIBBLES);
    check_res("after_abort", 32'h2345_6789, 1'b0, 1'b0);
    handoff;

    // Random operands with random back-pressure against a W-bit reference.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, es, ec, eo);
      issue(ra, rb, rs);
      out_ready = 1'($urandom_range(0, 1));
      wait_done("rnd", NIBBLES);
      out_ready = 1'b0;
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) tick;
      check_res("rnd", es, ec, eo);
      handoff;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
